wishbone_bus_if: RTL and testbench

- CPU-side Wishbone master that converts a pipeline memory-access request into a single Wishbone classic cycle.
- Sits between a CPU pipeline port (instruction fetch or MEM stage) and the SRAM Wishbone slave, or the bus interconnect in front of it.
- Holds the pipeline with stallreq_o until ack, buffers read data across external pipeline stalls, and tolerates flushes without aborting a bus cycle already in flight.

---
 rtl/wishbone_bus_if_pkg.sv | 14 +
 rtl/wishbone_bus_if.sv | 163 ++++++++++++++++
 tb/tb_wishbone_bus_if.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wishbone_bus_if_pkg.sv
// Shared definitions for the CPU-side Wishbone master: bus widths, reset level and FSM encodings.
package wishbone_bus_if_pkg;

    localparam int          RegBus    = 32;
    localparam logic [31:0] ZeroWord  = 32'h0000_0000;
    localparam logic        RstEnable = 1'b0;

    typedef enum logic [1:0] {
        WB_IDLE           = 2'b00,
        WB_BUSY           = 2'b01,
        WB_WAIT_FOR_STALL = 2'b10
    } wb_state_t;

endpackage

// File: rtl/wishbone_bus_if.sv
// Converts one pipeline memory request into a single Wishbone classic cycle.
// Optional bus timeout is enabled by defining BUS_TIMEOUT_EN.
module wishbone_bus_if
    import wishbone_bus_if_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall_i,
    input  logic                flush_i,
    input  logic                cpu_ce_i,
    input  logic [RegBus-1:0]   cpu_addr_i,
    input  logic [RegBus-1:0]   cpu_data_i,
    input  logic                cpu_we_i,
    input  logic [3:0]          cpu_sel_i,
    output logic [RegBus-1:0]   cpu_data_o,
    output logic                stallreq_o,
    output logic                bus_err_o,
    output logic [RegBus-1:0]   wishbone_addr_o,
    output logic [RegBus-1:0]   wishbone_data_o,
    output logic                wishbone_we_o,
    output logic [3:0]          wishbone_sel_o,
    output logic                wishbone_stb_o,
    output logic                wishbone_cyc_o,
    input  logic [RegBus-1:0]   wishbone_data_i,
    input  logic                wishbone_ack_i,
    output logic [1:0]          dbg_state
);

    // Handshake: stb&cyc is the master's valid, ack is the slave's ready; a transfer
    // completes on the edge where both are high, and every wishbone_*_o holds until then.

    wb_state_t          state, state_nxt;
    logic [RegBus-1:0]  rd_buf;
    logic               discard;
    logic               timeout;

`ifdef BUS_TIMEOUT_EN
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] to_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RstEnable) begin
            to_cnt <= 8'd0;
        end else if (state != WB_BUSY || wishbone_ack_i) begin
            to_cnt <= 8'd0;
        end else begin
            to_cnt <= to_cnt + 8'd1;
        end
    end

    assign timeout = (state == WB_BUSY) && !wishbone_ack_i && (to_cnt == TimeoutLast);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RstEnable) begin
            state <= WB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WB_IDLE: begin
                if (cpu_ce_i && !flush_i) state_nxt = WB_BUSY;
            end
            WB_BUSY: begin
                if (wishbone_ack_i) begin
                    if (discard)      state_nxt = WB_IDLE;
                    else if (stall_i) state_nxt = WB_WAIT_FOR_STALL;
                    else              state_nxt = WB_IDLE;
                end else if (timeout) begin
                    state_nxt = WB_IDLE;
                end
            end
            WB_WAIT_FOR_STALL: begin
                if (flush_i || !stall_i) state_nxt = WB_IDLE;
            end
            default: state_nxt = WB_IDLE;
        endcase
    end

    // Bus registers; a flush during BUSY only marks the cycle for discard since the slave cannot abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RstEnable) begin
            wishbone_addr_o <= ZeroWord;
            wishbone_data_o <= ZeroWord;
            wishbone_we_o   <= 1'b0;
            wishbone_sel_o  <= 4'b0000;
            wishbone_stb_o  <= 1'b0;
            wishbone_cyc_o  <= 1'b0;
            rd_buf          <= ZeroWord;
            discard         <= 1'b0;
        end else begin
            case (state)
                WB_IDLE: begin
                    if (cpu_ce_i && !flush_i) begin
                        wishbone_addr_o <= cpu_addr_i;
                        wishbone_data_o <= cpu_data_i;
                        wishbone_we_o   <= cpu_we_i;
                        wishbone_sel_o  <= cpu_sel_i;
                        wishbone_stb_o  <= 1'b1;
                        wishbone_cyc_o  <= 1'b1;
                    end
                end
                WB_BUSY: begin
                    if (wishbone_ack_i || timeout) begin
                        wishbone_addr_o <= ZeroWord;
                        wishbone_data_o <= ZeroWord;
                        wishbone_we_o   <= 1'b0;
                        wishbone_sel_o  <= 4'b0000;
                        wishbone_stb_o  <= 1'b0;
                        wishbone_cyc_o  <= 1'b0;
                        discard         <= 1'b0;
                        if (wishbone_ack_i && !discard && !wishbone_we_o) begin
                            rd_buf <= wishbone_data_i;
                        end
                    end else if (flush_i) begin
                        discard <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        cpu_data_o = ZeroWord;
        stallreq_o = 1'b0;
        bus_err_o  = 1'b0;
        case (state)
            WB_IDLE: begin
                stallreq_o = cpu_ce_i && !flush_i;
            end
            WB_BUSY: begin
                if (timeout) begin
                    bus_err_o = 1'b1;
                end else begin
                    stallreq_o = !wishbone_ack_i || discard;
                    if (wishbone_ack_i && !discard && !wishbone_we_o) begin
                        cpu_data_o = wishbone_data_i;
                    end
                end
            end
            WB_WAIT_FOR_STALL: begin
                cpu_data_o = rd_buf;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_wishbone_bus_if.sv
// Directed self-checking bench for wishbone_bus_if; define BUS_TIMEOUT_EN to cover the timeout path.
module tb_wishbone_bus_if;
    import wishbone_bus_if_pkg::*;

`ifdef BUS_TIMEOUT_EN
    localparam int TO_CYC = 8;
`else
    localparam int TO_CYC = 255;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        cpu_ce_i = 1'b0;
    logic [31:0] cpu_addr_i = '0;
    logic [31:0] cpu_data_i = '0;
    logic        cpu_we_i = 1'b0;
    logic [3:0]  cpu_sel_i = '0;
    logic [31:0] cpu_data_o;
    logic        stallreq_o;
    logic        bus_err_o;
    logic [31:0] wishbone_addr_o;
    logic [31:0] wishbone_data_o;
    logic        wishbone_we_o;
    logic [3:0]  wishbone_sel_o;
    logic        wishbone_stb_o;
    logic        wishbone_cyc_o;
    logic [31:0] wishbone_data_i = '0;
    logic        wishbone_ack_i = 1'b0;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    wishbone_bus_if #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .cpu_ce_i        (cpu_ce_i),
        .cpu_addr_i      (cpu_addr_i),
        .cpu_data_i      (cpu_data_i),
        .cpu_we_i        (cpu_we_i),
        .cpu_sel_i       (cpu_sel_i),
        .cpu_data_o      (cpu_data_o),
        .stallreq_o      (stallreq_o),
        .bus_err_o       (bus_err_o),
        .wishbone_addr_o (wishbone_addr_o),
        .wishbone_data_o (wishbone_data_o),
        .wishbone_we_o   (wishbone_we_o),
        .wishbone_sel_o  (wishbone_sel_o),
        .wishbone_stb_o  (wishbone_stb_o),
        .wishbone_cyc_o  (wishbone_cyc_o),
        .wishbone_data_i (wishbone_data_i),
        .wishbone_ack_i  (wishbone_ack_i),
        .dbg_state       (dbg_state)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; checks follow after a further unit.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic we, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] sel);
        cpu_ce_i   = 1'b1;
        cpu_we_i   = we;
        cpu_addr_i = addr;
        cpu_data_i = data;
        cpu_sel_i  = sel;
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_stb", {31'b0, wishbone_stb_o}, 32'd0);
        chk("rst_cyc", {31'b0, wishbone_cyc_o}, 32'd0);
        chk("rst_state", {30'b0, dbg_state}, {30'b0, WB_IDLE});
        chk("rst_addr", wishbone_addr_o, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // read, ack in third stb cycle
        req(1'b0, 32'h0000_0010, 32'h0, 4'hF);
        settle();
        chk("rd_idle_stallreq", {31'b0, stallreq_o}, 32'd1);
        chk("rd_idle_stb", {31'b0, wishbone_stb_o}, 32'd0);
        tick();
        chk("rd_c1_stb", {31'b0, wishbone_stb_o}, 32'd1);
        chk("rd_c1_cyc", {31'b0, wishbone_cyc_o}, 32'd1);
        chk("rd_c1_addr", wishbone_addr_o, 32'h0000_0010);
        chk("rd_c1_we", {31'b0, wishbone_we_o}, 32'd0);
        chk("rd_c1_stallreq", {31'b0, stallreq_o}, 32'd1);
        chk("rd_c1_data", cpu_data_o, 32'h0);
        tick();
        chk("rd_c2_stb", {31'b0, wishbone_stb_o}, 32'd1);
        chk("rd_c2_stallreq", {31'b0, stallreq_o}, 32'd1);
        tick();
        wishbone_ack_i  = 1'b1;
        wishbone_data_i = 32'hDEAD_BEEF;
        settle();
        chk("rd_ack_stb", {31'b0, wishbone_stb_o}, 32'd1);
        chk("rd_ack_data", cpu_data_o, 32'hDEAD_BEEF);
        chk("rd_ack_stallreq", {31'b0, stallreq_o}, 32'd0);
        tick();
        wishbone_ack_i  = 1'b0;
        wishbone_data_i = 32'h0;
        cpu_ce_i        = 1'b0;
        settle();
        chk("rd_post_stb", {31'b0, wishbone_stb_o}, 32'd0);
        chk("rd_post_cyc", {31'b0, wishbone_cyc_o}, 32'd0);
        chk("rd_post_addr", wishbone_addr_o, 32'h0);
        chk("rd_post_state", {30'b0, dbg_state}, {30'b0, WB_IDLE});

        // partial write
        req(1'b1, 32'h0000_0020, 32'h0000_AB00, 4'b0010);
        tick();
        chk("wr_sel", {28'b0, wishbone_sel_o}, 32'h2);
        chk("wr_we", {31'b0, wishbone_we_o}, 32'd1);
        chk("wr_wdata", wishbone_data_o, 32'h0000_AB00);
        chk("wr_c1_data", cpu_data_o, 32'h0);
        tick();
        wishbone_ack_i  = 1'b1;
        wishbone_data_i = 32'h5A5A_5A5A;
        settle();
        chk("wr_ack_data", cpu_data_o, 32'h0);
        chk("wr_ack_stallreq", {31'b0, stallreq_o}, 32'd0);
        chk("wr_ack_we", {31'b0, wishbone_we_o}, 32'd1);
        tick();
        wishbone_ack_i  = 1'b0;
        wishbone_data_i = 32'h0;
        cpu_ce_i        = 1'b0;
        settle();
        chk("wr_post_we", {31'b0, wishbone_we_o}, 32'd0);
        chk("wr_post_sel", {28'b0, wishbone_sel_o}, 32'h0);
        chk("wr_post_stb", {31'b0, wishbone_stb_o}, 32'd0);

        // read acked while the pipeline is stalled elsewhere
        req(1'b0, 32'h0000_0030, 32'h0, 4'hF);
        tick();
        tick();
        wishbone_ack_i  = 1'b1;
        wishbone_data_i = 32'h1234_5678;
        stall_i         = 1'b1;
        settle();
        chk("st_ack_data", cpu_data_o, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            tick();
            wishbone_ack_i  = 1'b0;
            wishbone_data_i = 32'hFFFF_FFFF;
            settle();
            chk("st_wait_state", {30'b0, dbg_state}, {30'b0, WB_WAIT_FOR_STALL});
            chk("st_wait_data", cpu_data_o, 32'h1234_5678);
            chk("st_wait_stb", {31'b0, wishbone_stb_o}, 32'd0);
            chk("st_wait_stallreq", {31'b0, stallreq_o}, 32'd0);
        end
        stall_i  = 1'b0;
        cpu_ce_i = 1'b0;
        settle();
        chk("st_release_data", cpu_data_o, 32'h1234_5678);
        tick();
        wishbone_data_i = 32'h0;
        settle();
        chk("st_idle_state", {30'b0, dbg_state}, {30'b0, WB_IDLE});
        chk("st_idle_stb", {31'b0, wishbone_stb_o}, 32'd0);
        chk("st_idle_data", cpu_data_o, 32'h0);

        // flush one cycle after stb rises
        req(1'b0, 32'h0000_0040, 32'h0, 4'hF);
        tick();
        flush_i = 1'b1;
        settle();
        chk("fl_stb_at_flush", {31'b0, wishbone_stb_o}, 32'd1);
        tick();
        flush_i  = 1'b0;
        cpu_ce_i = 1'b0;
        settle();
        chk("fl_stb_held", {31'b0, wishbone_stb_o}, 32'd1);
        chk("fl_stallreq_held", {31'b0, stallreq_o}, 32'd1);
        tick();
        wishbone_ack_i  = 1'b1;
        wishbone_data_i = 32'hCAFE_F00D;
        settle();
        chk("fl_ack_data", cpu_data_o, 32'h0);
        chk("fl_ack_stallreq", {31'b0, stallreq_o}, 32'd1);
        tick();
        wishbone_ack_i  = 1'b0;
        wishbone_data_i = 32'h0;
        settle();
        chk("fl_post_state", {30'b0, dbg_state}, {30'b0, WB_IDLE});
        chk("fl_post_stb", {31'b0, wishbone_stb_o}, 32'd0);
        req(1'b0, 32'h0000_0050, 32'h0, 4'hF);
        tick();
        chk("fl_next_stb", {31'b0, wishbone_stb_o}, 32'd1);
        chk("fl_next_addr", wishbone_addr_o, 32'h0000_0050);
        wishbone_ack_i  = 1'b1;
        wishbone_data_i = 32'h0000_0055;
        settle();
        chk("fl_next_data", cpu_data_o, 32'h0000_0055);
        tick();
        wishbone_ack_i  = 1'b0;
        wishbone_data_i = 32'h0;
        cpu_ce_i        = 1'b0;

        // request together with flush in IDLE is ignored
        req(1'b0, 32'h0000_0060, 32'h0, 4'hF);
        flush_i = 1'b1;
        settle();
        chk("fi_stallreq", {31'b0, stallreq_o}, 32'd0);
        tick();
        chk("fi_stb", {31'b0, wishbone_stb_o}, 32'd0);
        chk("fi_state", {30'b0, dbg_state}, {30'b0, WB_IDLE});
        flush_i  = 1'b0;
        cpu_ce_i = 1'b0;

        // async reset while BUSY
        req(1'b0, 32'h0000_0070, 32'h0, 4'hF);
        tick();
        chk("ar_busy_stb", {31'b0, wishbone_stb_o}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_stb", {31'b0, wishbone_stb_o}, 32'd0);
        chk("ar_cyc", {31'b0, wishbone_cyc_o}, 32'd0);
        chk("ar_addr", wishbone_addr_o, 32'h0);
        chk("ar_state", {30'b0, dbg_state}, {30'b0, WB_IDLE});
        cpu_ce_i = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar_post_state", {30'b0, dbg_state}, {30'b0, WB_IDLE});
        chk("ar_post_stb", {31'b0, wishbone_stb_o}, 32'd0);

`ifdef BUS_TIMEOUT_EN
        // never acked: terminated in the eighth BUSY cycle
        req(1'b0, 32'h0000_0080, 32'h0, 4'hF);
        for (int i = 1; i < TO_CYC; i++) begin
            tick();
            chk("to_busy_stb", {31'b0, wishbone_stb_o}, 32'd1);
            chk("to_busy_err", {31'b0, bus_err_o}, 32'd0);
        end
        tick();
        chk("to_fire_err", {31'b0, bus_err_o}, 32'd1);
        chk("to_fire_stallreq", {31'b0, stallreq_o}, 32'd0);
        chk("to_fire_data", cpu_data_o, 32'h0);
        cpu_ce_i = 1'b0;
        tick();
        chk("to_post_stb", {31'b0, wishbone_stb_o}, 32'd0);
        chk("to_post_cyc", {31'b0, wishbone_cyc_o}, 32'd0);
        chk("to_post_err", {31'b0, bus_err_o}, 32'd0);
        chk("to_post_state", {30'b0, dbg_state}, {30'b0, WB_IDLE});
`else
        // without the timeout feature BUSY waits as long as the slave takes
        req(1'b0, 32'h0000_0080, 32'h0, 4'hF);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("nt_busy_stb", {31'b0, wishbone_stb_o}, 32'd1);
            chk("nt_busy_err", {31'b0, bus_err_o}, 32'd0);
        end
        wishbone_ack_i  = 1'b1;
        wishbone_data_i = 32'h0BAD_CAFE;
        settle();
        chk("nt_ack_data", cpu_data_o, 32'h0BAD_CAFE);
        tick();
        wishbone_ack_i  = 1'b0;
        wishbone_data_i = 32'h0;
        cpu_ce_i        = 1'b0;
        settle();
        chk("nt_post_stb", {31'b0, wishbone_stb_o}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
